wb_accel_slave: RTL

- Wishbone B3 classic slave front-end between the tile bus slave port and a streaming accelerator core (SHA256, AES, DES3, FIR, DFT, and similar).
- Converts register reads and writes into a valid/ready word stream toward the core.
- Collects the core's result stream into a readable buffer.
- Sequences each job with a start/busy/done state machine so software on a remote tile can drive the core over the NoC.

---
 rtl/wb_accel_pkg.sv | 28 ++
 rtl/wb_accel_fifo.sv | 62 ++++++
 rtl/wb_accel_slave.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_accel_pkg.sv
// Shared constants and types for the Wishbone accelerator slave: register map,
// CTRL/STATUS bit positions and the job sequencing state enum.
package wb_accel_pkg;

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegStatus  = 3'd1;
  localparam logic [2:0] RegDataIn  = 3'd2;
  localparam logic [2:0] RegDataOut = 3'd3;
  localparam logic [2:0] RegIrqEn   = 3'd4;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlClearBit = 1;

  localparam int unsigned BitBusy     = 0;
  localparam int unsigned BitDone     = 1;
  localparam int unsigned BitInFull   = 2;
  localparam int unsigned BitInEmpty  = 3;
  localparam int unsigned BitOutFull  = 4;
  localparam int unsigned BitOutEmpty = 5;
  localparam int unsigned BitErr      = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/wb_accel_fifo.sv
// Synchronous FIFO with flush; push on a full FIFO is accepted only together with a pop.
module wb_accel_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_accel_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FullCnt);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/wb_accel_slave.sv
// Wishbone B3 classic slave front-end for a streaming accelerator core.
// Optional macro WB_ACCEL_IRQ_EN enables the IRQ_EN register and the done interrupt.
module wb_accel_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_LSB   = 2
) (
  input  logic                  clk,
  input  logic                  rst_sys_n,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  core_start,
  output logic                  core_clear,
  output logic [DATA_WIDTH-1:0] core_in_data,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  input  logic [DATA_WIDTH-1:0] core_out_data,
  input  logic                  core_out_valid,
  output logic                  core_out_ready,
  input  logic                  core_done,
  output logic                  irq
);

  import wb_accel_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("wb_accel_slave: DATA_WIDTH must be 32");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_ack;
  logic                  r_wb_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_core_start;
  logic                  r_core_clear;
  logic                  r_done;
  logic                  r_err_sticky;

  logic [2:0]            w_idx;
  logic                  w_req;
  logic                  w_acc_err;
  logic                  w_ok;
  logic                  w_bad;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_irq_en_rd;
  logic                  w_ctrl_wr;
  logic                  w_clear;
  logic                  w_start;
  logic                  w_go;
  logic                  w_start_err;
  logic                  w_done_set;

  logic                  w_in_push;
  logic                  w_in_pop;
  logic                  w_in_full;
  logic                  w_in_empty;
  logic [CW-1:0]         w_in_count;
  logic                  w_out_push;
  logic                  w_out_pop;
  logic                  w_out_full;
  logic                  w_out_empty;
  logic [CW-1:0]         w_out_count;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_unused;

  // Byte selects and undecoded address bits are intentionally ignored.
  assign w_unused = ^{wb_adr_i, wb_sel_i};

  assign w_idx = wb_adr_i[ADDR_LSB+2:ADDR_LSB];
  assign w_req = wb_cyc_i & wb_stb_i & ~r_ack & ~r_wb_err;

  always_comb begin
    w_status              = '0;
    w_status[BitBusy]     = (r_state == StRun);
    w_status[BitDone]     = r_done;
    w_status[BitInFull]   = w_in_full;
    w_status[BitInEmpty]  = w_in_empty;
    w_status[BitOutFull]  = w_out_full;
    w_status[BitOutEmpty] = w_out_empty;
    w_status[BitErr]      = r_err_sticky;
    w_status[15:8]        = 8'(w_in_count);
    w_status[23:16]       = 8'(w_out_count);
  end

  always_comb begin
    w_acc_err = 1'b0;
    w_rdata   = '0;
    case (w_idx)
      RegCtrl:    w_acc_err = 1'b0;
      RegStatus:  begin
        w_acc_err = wb_we_i;
        w_rdata   = w_status;
      end
      RegDataIn:  w_acc_err = ~wb_we_i | w_in_full;
      RegDataOut: begin
        w_acc_err = wb_we_i | w_out_empty;
        w_rdata   = w_out_data;
      end
      RegIrqEn:   w_rdata = w_irq_en_rd;
      default:    w_acc_err = 1'b1;
    endcase
  end

  assign w_ok      = w_req & ~w_acc_err;
  assign w_bad     = w_req & w_acc_err;
  assign w_in_push = w_ok & wb_we_i & (w_idx == RegDataIn);
  assign w_out_pop = w_ok & ~wb_we_i & (w_idx == RegDataOut);
  assign w_ctrl_wr = w_ok & wb_we_i & (w_idx == RegCtrl);
  assign w_clear   = w_ctrl_wr & wb_dat_i[CtrlClearBit];
  assign w_start   = w_ctrl_wr & wb_dat_i[CtrlStartBit] & ~w_clear;

  assign core_in_valid  = (r_state == StRun) & ~w_in_empty;
  assign w_in_pop       = core_in_valid & core_in_ready;
  assign core_out_ready = ~w_out_full;
  assign w_out_push     = core_out_valid & core_out_ready;

  // Clear wins over everything, including a core_done in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_start_err = 1'b0;
    w_done_set  = 1'b0;
    if (w_clear) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (w_start) begin
            if (w_in_empty) begin
              w_start_err = 1'b1;
            end else begin
              w_state_nxt = StRun;
              w_go        = 1'b1;
            end
          end
        end
        StRun: begin
          if (core_done) begin
            w_state_nxt = StDone;
            w_done_set  = 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state      <= StIdle;
      r_ack        <= 1'b0;
      r_wb_err     <= 1'b0;
      r_dat        <= '0;
      r_core_start <= 1'b0;
      r_core_clear <= 1'b0;
      r_done       <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack        <= w_ok;
      r_wb_err     <= w_bad;
      r_dat        <= (w_ok && !wb_we_i) ? w_rdata : '0;
      r_core_start <= w_go;
      r_core_clear <= w_clear;
      if (w_clear || w_go) r_done <= 1'b0;
      else if (w_done_set) r_done <= 1'b1;
      if (w_clear) r_err_sticky <= 1'b0;
      else if (w_bad || w_start_err) r_err_sticky <= 1'b1;
    end
  end

`ifdef WB_ACCEL_IRQ_EN
  logic r_irq_en;

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_irq_en <= 1'b0;
    end else if (w_ok && wb_we_i && (w_idx == RegIrqEn)) begin
      r_irq_en <= wb_dat_i[0];
    end
  end

  assign w_irq_en_rd = {{(DATA_WIDTH-1){1'b0}}, r_irq_en};
  assign irq         = r_irq_en & r_done;
`else
  assign w_irq_en_rd = '0;
  assign irq         = 1'b0;
`endif

  wb_accel_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .rst_n   (rst_sys_n),
    .i_flush (w_clear),
    .i_push  (w_in_push),
    .i_data  (wb_dat_i),
    .i_pop   (w_in_pop),
    .o_data  (core_in_data),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_count (w_in_count)
  );

  wb_accel_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_sys_n),
    .i_flush (w_clear),
    .i_push  (w_out_push),
    .i_data  (core_out_data),
    .i_pop   (w_out_pop),
    .o_data  (w_out_data),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_count (w_out_count)
  );

  assign wb_dat_o   = r_dat;
  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_wb_err;
  assign wb_rty_o   = 1'b0;
  assign core_start = r_core_start;
  assign core_clear = r_core_clear;

endmodule
